fetch_slot_sequencer: RTL and testbench
=======================================

FETCH_SLOT_SEQUENCER -- requirements
Module: fetch_slot_sequencer

Interface
REQ-001 Parameter INSTR_PER_FETCH, default 4: number of realigned instruction slots per fetch block (legal values 2 or 4).
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  discard all buffered slots (frontend redirect).
REQ-005 blk_valid_i  input  1  realigner output block is valid this cycle.
REQ-006 blk_ready_o  output  1  block accepted this cycle; also drives the realigner enable.
REQ-007 slot_valid_i  input  INSTR_PER_FETCH  per-slot valid from the realigner.
REQ-008 slot_instr_i  input  INSTR_PER_FETCH x 32  per-slot instruction.
REQ-009 slot_addr_i  input  INSTR_PER_FETCH x 64  per-slot instruction address.
REQ-010 slot_taken_i  input  INSTR_PER_FETCH  per-slot predicted-taken flag.
REQ-011 instr_valid_o  output  1  one instruction is presented downstream.
REQ-012 instr_ready_i  input  1  downstream accepts the presented instruction.
REQ-013 instr_o  output  32  presented instruction.
REQ-014 addr_o  output  64  presented instruction address.
REQ-015 taken_o  output  1  presented instruction is predicted taken.
REQ-016 busy_o  output  1  the buffer holds at least one pending slot.

Function
REQ-017 The block SHALL hold one registered buffer of INSTR_PER_FETCH slots (instr, addr, taken) plus a pending mask, with states EMPTY (mask zero) and DRAIN (mask non-zero).
REQ-018 Accept SHALL occur when blk_valid_i && blk_ready_o && !flush_i.
REQ-019 On accept, the mask SHALL load slot_valid_i with every bit above the lowest valid slot whose slot_taken_i is set cleared (post-branch slots dropped).
REQ-020 An accepted block with a resulting mask of zero SHALL leave the state EMPTY and produce no output.
REQ-021 blk_ready_o SHALL equal (state == EMPTY) || (instr_ready_i && mask has exactly one bit set), combinationally; it SHALL be 0 while flush_i is high.
REQ-022 instr_valid_o SHALL equal (mask != 0); instr_o, addr_o and taken_o SHALL come from the lowest-index set mask bit, driven from registers only (no input-to-output combinational path).
REQ-023 Latency from accept to instr_valid_o SHALL be exactly 1 cycle.
REQ-024 On instr_valid_o && instr_ready_i the lowest set mask bit SHALL clear at the next edge; at most one instruction is delivered per cycle.
REQ-025 When the last pending slot is consumed and a new block is accepted in the same cycle, the new block SHALL load with no bubble cycle.
REQ-026 While instr_valid_o is high and instr_ready_i is low, instr_o, addr_o and taken_o SHALL remain stable.
REQ-027 flush_i SHALL clear the mask at the next edge regardless of any other input; flush takes priority over accept and consume in the same cycle.
REQ-028 busy_o SHALL equal (mask != 0).
REQ-029 Slot data registers SHALL update only on accept; mask bits beyond slot_valid_i SHALL never be set.

Reset
REQ-030 While rst_ni is low the mask SHALL be zero, with instr_valid_o=0, busy_o=0 and blk_ready_o=1; data registers SHALL reset to zero.
REQ-031 Reset asserted mid-drain SHALL drop all pending slots immediately, with no further delivery after deassertion until a new accept.

Verification
REQ-032 Accept block with slot_valid=4'b1111, taken=0, instr_ready held 1 -> instr_valid_o high for 4 consecutive cycles in slot order 0,1,2,3; blk_ready_o=1 in the 4th cycle.
REQ-033 slot_valid=4'b1011, slot_taken=4'b0010 -> exactly slots 0 and 1 delivered, taken_o=1 on slot 1, slot 3 is never presented.
REQ-034 instr_ready_i=0 for 3 cycles while slot 0 (addr 0x80000000) is presented -> outputs stable, blk_ready_o=0, then normal drain.
REQ-035 Continuous blk_valid_i with single-slot blocks (slot_valid=4'b0001) and instr_ready_i=1 -> one instruction per cycle with no bubbles.
REQ-036 flush_i asserted with 2 slots pending and blk_valid_i=1 -> next cycle instr_valid_o=0, busy_o=0, and the concurrent block is not accepted.
REQ-037 rst_ni pulsed low mid-drain -> outputs go to reset values asynchronously; after release blk_ready_o=1 and instr_valid_o=0.

Source files
------------

// File: rtl/fetch_slot_sequencer.sv
// Fetch slot sequencer: buffers one realigned fetch block and hands its slots
// downstream one per cycle, dropping slots that follow a predicted-taken branch.
module fetch_slot_sequencer #(
  parameter int INSTR_PER_FETCH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              blk_valid_i,
  output logic                              blk_ready_o,
  input  logic [INSTR_PER_FETCH-1:0]        slot_valid_i,
  input  logic [INSTR_PER_FETCH-1:0][31:0]  slot_instr_i,
  input  logic [INSTR_PER_FETCH-1:0][63:0]  slot_addr_i,
  input  logic [INSTR_PER_FETCH-1:0]        slot_taken_i,
  output logic                              instr_valid_o,
  input  logic                              instr_ready_i,
  output logic [31:0]                       instr_o,
  output logic [63:0]                       addr_o,
  output logic                              taken_o,
  output logic                              busy_o
);

  localparam int N  = INSTR_PER_FETCH;
  localparam int SW = $clog2(N);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Handshakes: a block transfers when blk_valid_i && blk_ready_o && !flush_i;
  // an instruction transfers when instr_valid_o && instr_ready_i.

  logic [N-1:0]        mask_q, mask_d;
  logic [N-1:0][31:0]  instr_q, instr_d;
  logic [N-1:0][63:0]  addr_q, addr_d;
  logic [N-1:0]        taken_q, taken_d;

  logic [0:0]   state;
  logic         last_slot;
  logic         accept;
  logic         consume;
  logic [N-1:0] acc_mask;
  logic         cut_found;
  logic [SW-1:0] sel;

  assign state     = (mask_q != '0) ? DRAIN : EMPTY;
  assign last_slot = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);

  assign blk_ready_o   = !flush_i && ((state == EMPTY) || (instr_ready_i && last_slot));
  assign accept        = blk_valid_i && blk_ready_o && !flush_i;
  assign instr_valid_o = (state == DRAIN);
  assign consume       = instr_valid_o && instr_ready_i;
  assign busy_o        = (mask_q != '0);

  // Keep valid slots up to and including the first predicted-taken one.
  always_comb begin
    acc_mask  = slot_valid_i;
    cut_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cut_found) acc_mask[i] = 1'b0;
      if (slot_valid_i[i] && slot_taken_i[i]) cut_found = 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) sel = SW'(i);
    end
  end

  assign instr_o = instr_q[sel];
  assign addr_o  = addr_q[sel];
  assign taken_o = taken_q[sel];

  always_comb begin
    mask_d  = mask_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    taken_d = taken_q;
    if (flush_i) begin
      mask_d = '0;
    end else if (accept) begin
      mask_d  = acc_mask;
      instr_d = slot_instr_i;
      addr_d  = slot_addr_i;
      taken_d = slot_taken_i;
    end else if (consume) begin
      mask_d = mask_q & (mask_q - N'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q  <= '0;
      instr_q <= '0;
      addr_q  <= '0;
      taken_q <= '0;
    end else begin
      mask_q  <= mask_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: tb/tb_fetch_slot_sequencer.sv
// Bench for fetch_slot_sequencer: a queue of pending {taken, addr, instr} slots
// models the buffer; outputs are sampled just after the falling edge.
module tb_fetch_slot_sequencer;

  localparam int N = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              blk_valid;
  logic              blk_ready;
  logic [N-1:0]      slot_valid;
  logic [N-1:0][31:0] slot_instr;
  logic [N-1:0][63:0] slot_addr;
  logic [N-1:0]      slot_taken;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [63:0]       addr;
  logic              taken;
  logic              busy;

  logic [96:0] exp_q[$];
  int checks;
  int errors;

  fetch_slot_sequencer #(.INSTR_PER_FETCH(N)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .blk_valid_i   (blk_valid),
    .blk_ready_o   (blk_ready),
    .slot_valid_i  (slot_valid),
    .slot_instr_i  (slot_instr),
    .slot_addr_i   (slot_addr),
    .slot_taken_i  (slot_taken),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .addr_o        (addr),
    .taken_o       (taken),
    .busy_o        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [96:0] got, input logic [96:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, update model.
  task automatic step(input logic bv, input logic [N-1:0] sv, input logic [N-1:0] st,
                      input logic rdy, input logic fl, input logic [63:0] base);
    logic exp_ready;
    int   cut;
    @(negedge clk);
    blk_valid   = bv;
    slot_valid  = sv;
    slot_taken  = st;
    instr_ready = rdy;
    flush       = fl;
    for (int i = 0; i < N; i++) begin
      slot_instr[i] = $urandom;
      slot_addr[i]  = base + 64'(4 * i);
    end
    #1;
    exp_ready = !fl && (exp_q.size() == 0 || (rdy && exp_q.size() == 1));
    check("blk_ready", {96'd0, blk_ready}, {96'd0, exp_ready});
    check("instr_valid", {96'd0, instr_valid}, {96'd0, exp_q.size() != 0});
    check("busy", {96'd0, busy}, {96'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("slot", {taken, addr, instr}, exp_q[0]);
      if (rdy) void'(exp_q.pop_front());
    end
    if (fl) begin
      exp_q.delete();
    end else if (bv && exp_ready) begin
      cut = N;
      for (int i = N - 1; i >= 0; i--) if (sv[i] && st[i]) cut = i;
      for (int i = 0; i < N; i++)
        if (sv[i] && i <= cut) exp_q.push_back({st[i], slot_addr[i], slot_instr[i]});
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    blk_valid   = 1'b0;
    slot_valid  = '0;
    slot_taken  = '0;
    slot_instr  = '0;
    slot_addr   = '0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {96'd0, blk_ready}, 97'd1);
    check("rst_valid", {96'd0, instr_valid}, 97'd0);
    check("rst_busy", {96'd0, busy}, 97'd0);
    check("rst_data", {taken, addr, instr}, 97'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full block, drained back to back.
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 64'h1000);
    repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Taken branch in slot 1 drops slot 3.
    step(1'b1, 4'b1011, 4'b0010, 1'b1, 1'b0, 64'h2000);
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Downstream stall on slot 0 at 0x80000000.
    step(1'b1, 4'b0111, 4'b0000, 1'b0, 1'b0, 64'h8000_0000);
    repeat (3) step(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 64'h9000);
    repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Single-slot blocks streamed with no bubbles.
    for (int k = 0; k < 8; k++) step(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 64'h3000 + 64'(16 * k));
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Block with nothing valid leaves the buffer empty.
    step(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 64'h4000);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Flush with two pending and a competing block.
    step(1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 64'h5000);
    step(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 64'h6000);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Random traffic.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0, {$urandom, $urandom} & ~64'h3);
    repeat (4) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    // Reset pulsed mid-drain.
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 64'h7000);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {96'd0, instr_valid}, 97'd0);
    check("async_busy", {96'd0, busy}, 97'd0);
    check("async_ready", {96'd0, blk_ready}, 97'd1);
    check("async_data", {taken, addr, instr}, 97'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
